// File: rtl/serial_pad_poller.sv
// serial_pad_poller: polls N_PADS SNES-style serial pads on a shared latch/clock and serves button + pressed-edge state over an AXI-Lite read slave.
// Build option PAD_DEBOUNCE_EN: a button bit only changes after two consecutive agreeing frames.
module serial_pad_poller #(
  parameter int N_PADS      = 2,
  parameter int PAD_BITS    = 16,
  parameter int KEEP_BITS   = 12,
  parameter int CLK_DIV     = 300,
  parameter int POLL_PERIOD = 333333,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_PADS-1:0] pad_data,
  output logic              pad_clk,
  output logic              pad_latch,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready
);
  localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int BW = (PAD_BITS > 1) ? $clog2(PAD_BITS) : 1;
  localparam logic [15:0] KEEP_MASK = 16'((32'd1 << KEEP_BITS) - 32'd1);

  typedef enum logic [2:0] {IDLE, LATCH, GAP, SHIFT, COMMIT} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [BW-1:0]       bit_idx, bit_n;
  logic [TW-1:0]       timer;
  logic                clk_n, latch_n;
  logic [N_PADS-1:0]   data_meta, data_sync;
  logic [PAD_BITS-1:0] shift_q [N_PADS];
  logic [15:0]         btn_q [N_PADS];
  logic [15:0]         pressed_q [N_PADS];
  logic [15:0]         new_bits [N_PADS];
  logic [15:0]         btn_nx [N_PADS];
  logic [15:0]         pressed_nx [N_PADS];
  logic [15:0]         frame_cnt;
  logic                busy, ar_hs, rd_err;
  logic [31:0]         rd_dat, widx;
`ifdef PAD_DEBOUNCE_EN
  logic [15:0]         prev_q [N_PADS];
`endif

  assign busy  = (state != IDLE);
  assign widx  = 32'(s_axil_araddr[ADDR_W-1:2]);
  assign ar_hs = s_axil_arvalid & ~s_axil_rvalid;
  assign s_axil_arready = ~s_axil_rvalid;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (timer == '0) state_n = LATCH;
      end
      LATCH: begin
        if (cnt == CW'(2 * CLK_DIV - 1)) begin
          state_n = GAP;
          cnt_n   = '0;
        end
      end
      GAP: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          state_n = SHIFT;
          cnt_n   = '0;
          bit_n   = '0;
        end
      end
      SHIFT: begin
        if (cnt == CW'(2 * CLK_DIV - 1)) begin
          cnt_n = '0;
          if (bit_idx == BW'(PAD_BITS - 1)) state_n = COMMIT;
          else bit_n = bit_idx + BW'(1);
        end
      end
      COMMIT: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    // Pins are registered from the next state so they align exactly with the state they belong to.
    latch_n = (state_n == LATCH);
    clk_n   = !((state_n == SHIFT) && (cnt_n < CW'(CLK_DIV)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      timer     <= '0;
      pad_clk   <= 1'b1;
      pad_latch <= 1'b0;
      data_meta <= '1;
      data_sync <= '1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      timer     <= (timer == TW'(POLL_PERIOD - 1)) ? '0 : timer + TW'(1);
      pad_clk   <= clk_n;
      pad_latch <= latch_n;
      data_meta <= pad_data;
      data_sync <= data_meta;
    end
  end

  always_comb begin
    for (int p = 0; p < N_PADS; p++) begin
      new_bits[p] = 16'(shift_q[p]) & KEEP_MASK;
`ifdef PAD_DEBOUNCE_EN
      btn_nx[p] = (btn_q[p] & (new_bits[p] ^ prev_q[p])) | (new_bits[p] & ~(new_bits[p] ^ prev_q[p]));
`else
      btn_nx[p] = new_bits[p];
`endif
      // Read-clear wins over the old edges, never over the edges committed this cycle.
      pressed_nx[p] = ((ar_hs && (widx == 32'(p))) ? 16'h0000 : pressed_q[p]) |
                      ((state == COMMIT) ? (btn_nx[p] & ~btn_q[p]) : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < N_PADS; p++) begin
        shift_q[p]   <= '0;
        btn_q[p]     <= '0;
        pressed_q[p] <= '0;
`ifdef PAD_DEBOUNCE_EN
        prev_q[p]    <= '0;
`endif
      end
      frame_cnt <= '0;
    end else begin
      for (int p = 0; p < N_PADS; p++) begin
        if ((state == SHIFT) && (cnt == '0)) shift_q[p][bit_idx] <= ~data_sync[p];
        pressed_q[p] <= pressed_nx[p];
        if (state == COMMIT) begin
          btn_q[p]  <= btn_nx[p];
`ifdef PAD_DEBOUNCE_EN
          prev_q[p] <= new_bits[p];
`endif
        end
      end
      if (state == COMMIT) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_dat = '0;
    rd_err = 1'b1;
    for (int p = 0; p < N_PADS; p++) begin
      if (widx == 32'(p)) begin
        rd_dat = {pressed_q[p], btn_q[p]};
        rd_err = 1'b0;
      end
    end
    if (widx == 32'(N_PADS)) begin
      rd_dat = {15'b0, busy, frame_cnt};
      rd_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= '0;
    end else if (ar_hs) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_dat;
      s_axil_rresp  <= rd_err ? 2'b10 : 2'b00;
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end
endmodule
